// File: rtl/routex_pkg.sv
// Shared types for the routex link: beat geometry and the source arbiter state set.
package routex_pkg;

  localparam int unsigned LANES = 8;
  localparam int unsigned WIDTH = 64;

  typedef logic [WIDTH-1:0] word_t;
  typedef word_t [LANES-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/routex_rr_pick.sv
// Combinational round-robin picker: first VALID requester searching upward from ptr+1, wrapping.
module routex_rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         valid,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     found
);

  localparam int unsigned IDW = $clog2(N_REQ);

  int unsigned c;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    // Offset 1 first so the last winner sits at the back of the queue.
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      c = (32'(ptr) + i) % N_REQ;
      if (!found && valid[IDW'(c)]) begin
        found         = 1'b1;
        idx           = IDW'(c);
        gnt[IDW'(c)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/routex_src_arb.sv
// Round-robin frame arbiter onto the shared routex beat bus, with inter-frame gap and stall abort.
module routex_src_arb
  import routex_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned IFG     = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  beat_t [N_REQ-1:0]        REQ_D,
  input  logic [N_REQ-1:0]         REQ_VALID,
  input  logic [N_REQ-1:0]         REQ_LAST,
  output logic [N_REQ-1:0]         REQ_READY,
  output beat_t                    D,
  output logic                     D_VALID,
  output logic [N_REQ-1:0]         GNT,
  output logic [$clog2(N_REQ)-1:0] GNT_ID,
  output logic                     BUSY,
  output logic                     ABORT
);

  localparam int unsigned IDW      = $clog2(N_REQ);
  localparam int unsigned SCW      = $clog2(TIMEOUT + 1);
  localparam int unsigned GW       = 4;
  localparam int unsigned IFG_LAST = (IFG > 0) ? IFG - 1 : 0;

  arb_state_t       state, state_nxt;
  logic [IDW-1:0]   ptr, ptr_nxt;
  logic [SCW-1:0]   scnt, scnt_nxt;
  logic [GW-1:0]    gcnt, gcnt_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [IDW-1:0]   gnt_id_nxt;
  beat_t            d_nxt;
  logic             d_valid_nxt;
  logic             abort_nxt;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDW-1:0]   pick_idx;
  logic             pick_found;
  logic             accept;

  routex_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .valid (REQ_VALID),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // GNT is only non-zero in XFER, so READY depends on registers alone.
  assign REQ_READY = GNT;
  assign accept    = (state == XFER) && REQ_VALID[GNT_ID];

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    scnt_nxt    = scnt;
    gcnt_nxt    = gcnt;
    gnt_nxt     = GNT;
    gnt_id_nxt  = GNT_ID;
    d_nxt       = D;
    d_valid_nxt = 1'b0;
    abort_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt  = XFER;
          gnt_nxt    = pick_gnt;
          gnt_id_nxt = pick_idx;
          ptr_nxt    = pick_idx;
          scnt_nxt   = '0;
        end
      end

      XFER: begin
        if (accept) begin
          d_nxt       = REQ_D[GNT_ID];
          d_valid_nxt = 1'b1;
          scnt_nxt    = '0;
          if (REQ_LAST[GNT_ID]) begin
            gnt_nxt   = '0;
            gcnt_nxt  = '0;
            state_nxt = (IFG > 0) ? GAP : IDLE;
          end
        end else begin
          scnt_nxt = SCW'(scnt + 1'b1);
          // This stall is the TIMEOUT-th in a row: drop the frame.
          if (scnt == SCW'(TIMEOUT - 1)) begin
            gnt_nxt   = '0;
            gcnt_nxt  = '0;
            abort_nxt = 1'b1;
            state_nxt = (IFG > 0) ? GAP : IDLE;
          end
        end
      end

      GAP: begin
        if (gcnt == GW'(IFG_LAST)) begin
          state_nxt = IDLE;
        end else begin
          gcnt_nxt = GW'(gcnt + 1'b1);
        end
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      ptr     <= IDW'(N_REQ - 1);
      scnt    <= '0;
      gcnt    <= '0;
      GNT     <= '0;
      GNT_ID  <= '0;
      D       <= '0;
      D_VALID <= 1'b0;
      BUSY    <= 1'b0;
      ABORT   <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      scnt    <= scnt_nxt;
      gcnt    <= gcnt_nxt;
      GNT     <= gnt_nxt;
      GNT_ID  <= gnt_id_nxt;
      D       <= d_nxt;
      D_VALID <= d_valid_nxt;
      BUSY    <= (state_nxt != IDLE);
      ABORT   <= abort_nxt;
    end
  end

endmodule
